// File: rtl/mem_stage_bus.sv
// mem_stage_bus: MEM pipeline stage of the 5-stage RV32 core, reaching data
// memory over a variable-latency req/gnt/rvalid bus.
//   - builds byte enables and lane-replicated store data from funct3/address
//   - detects misaligned half/word accesses (no bus request, misalignM pulse)
//   - aligns and sign/zero-extends load data
//   - stalls IF..MEM while a transaction is outstanding; a response that has
//     not arrived TIMEOUT cycles after grant raises a buserrM pulse
//   - registers results into the MEM/WB pipeline register
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   validM, strCtrlM          MEM instruction valid, funct3 (size/unsigned)
//   RegWriteM..MemtoRegM      control from EX/MEM
//   ALUoutM, r2M, rdM         address/ALU result, store data, dest register
//   dmem_*                    data bus (req/we/addr/wmask/wdata out,
//                             gnt/rvalid/rdata in)
//   stallM, misalignM,        pipeline freeze, misaligned pulse,
//   buserrM                   response timeout pulse
//   ALUoutW..RegWriteW        MEM/WB pipeline register
module mem_stage_bus #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validM,
  input  logic [2:0]        strCtrlM,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic              MemtoRegM,
  input  logic [31:0]       ALUoutM,
  input  logic [31:0]       r2M,
  input  logic [4:0]        rdM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              stallM,
  output logic              misalignM,
  output logic              buserrM,
  output logic [31:0]       ALUoutW,
  output logic [31:0]       ReadDataW,
  output logic [4:0]        rdW,
  output logic              MemtoRegW,
  output logic              RegWriteW
);

  localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t          state, stateN;
  logic [TW-1:0]   timer, timerN;

  logic            acc;
  logic            misal;
  logic [3:0]      combMask;
  logic [31:0]     combWdata;
  logic [ADDR_W-1:0] combAddr;

  // Request snapshot taken at launch so the bus sees stable values until grant
  logic              reqWe;
  logic [ADDR_W-1:0] reqAddr;
  logic [3:0]        reqMask;
  logic [31:0]       reqWdata;
  logic [1:0]        reqLane;
  logic [1:0]        reqSize;
  logic              reqUns;

  logic [1:0]      selLane;
  logic [1:0]      selSize;
  logic            selUns;
  logic [31:0]     loadData;

  logic            reqOut;
  logic            stall;
  logic            misalC;
  logic            buserrC;
  logic            done;
  logic            fail;
  logic            launch;

  // ---------------------------------------------------------------------
  // Access decode, byte enables, store lanes
  // ---------------------------------------------------------------------
  assign acc = validM & (MemReadM | MemWriteM);

  always_comb begin
    misal     = 1'b0;
    combMask  = 4'b1111;
    combWdata = r2M;
    case (strCtrlM[1:0])
      2'b00: begin
        combMask  = 4'b0001 << ALUoutM[1:0];
        combWdata = {4{r2M[7:0]}};
      end
      2'b01: begin
        misal     = ALUoutM[0];
        combMask  = ALUoutM[1] ? 4'b1100 : 4'b0011;
        combWdata = {2{r2M[15:0]}};
      end
      default: begin
        misal     = |ALUoutM[1:0];
        combMask  = 4'b1111;
        combWdata = r2M;
      end
    endcase
  end

  always_comb begin
    combAddr      = ALUoutM[ADDR_W-1:0];
    combAddr[1:0] = 2'b00;
  end

  // ---------------------------------------------------------------------
  // Load alignment / extension
  // ---------------------------------------------------------------------
  function automatic logic [31:0] fmtLoad(input logic [31:0] w,
                                          input logic [1:0]  lane,
                                          input logic [1:0]  sz,
                                          input logic        uns);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = lane[1] ? w[31:16] : w[15:0];
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (sz)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // In IDLE the access is launched from live inputs; afterwards the snapshot
  // is authoritative.
  always_comb begin
    if (state == IDLE) begin
      selLane = ALUoutM[1:0];
      selSize = strCtrlM[1:0];
      selUns  = strCtrlM[2];
    end else begin
      selLane = reqLane;
      selSize = reqSize;
      selUns  = reqUns;
    end
  end

  assign loadData = fmtLoad(dmem_rdata, selLane, selSize, selUns);

  // ---------------------------------------------------------------------
  // Bus FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= stateN;
      timer <= timerN;
    end
  end

  always_comb begin
    stateN  = state;
    timerN  = timer;
    reqOut  = 1'b0;
    stall   = 1'b0;
    misalC  = 1'b0;
    buserrC = 1'b0;
    done    = 1'b0;
    fail    = 1'b0;
    launch  = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (misal) begin
            misalC = 1'b1;
            fail   = 1'b1;
          end else begin
            reqOut = 1'b1;
            launch = 1'b1;
            if (dmem_gnt && dmem_rvalid) begin
              done = 1'b1;
            end else if (dmem_gnt) begin
              stateN = WAIT;
              timerN = '0;
              stall  = 1'b1;
            end else begin
              stateN = REQ;
              stall  = 1'b1;
            end
          end
        end
      end
      REQ: begin
        reqOut = 1'b1;
        if (dmem_gnt && dmem_rvalid) begin
          done   = 1'b1;
          stateN = IDLE;
        end else if (dmem_gnt) begin
          stateN = WAIT;
          timerN = '0;
          stall  = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          done   = 1'b1;
          stateN = IDLE;
        end else if (timer == TW'(TIMEOUT)) begin
          // Timer counts whole WAIT cycles without a response; the error is
          // declared in the cycle after TIMEOUT of them have elapsed.
          buserrC = 1'b1;
          fail    = 1'b1;
          stateN  = IDLE;
        end else begin
          timerN = timer + 1'b1;
          stall  = 1'b1;
        end
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reqWe    <= 1'b0;
      reqAddr  <= '0;
      reqMask  <= '0;
      reqWdata <= '0;
      reqLane  <= '0;
      reqSize  <= '0;
      reqUns   <= 1'b0;
    end else if (launch) begin
      reqWe    <= MemWriteM;
      reqAddr  <= combAddr;
      reqMask  <= combMask;
      reqWdata <= combWdata;
      reqLane  <= ALUoutM[1:0];
      reqSize  <= strCtrlM[1:0];
      reqUns   <= strCtrlM[2];
    end
  end

  // Pulses and handshakes are forced low combinationally while in reset
  assign dmem_req  = reqOut & ~rst;
  assign stallM    = stall & ~rst;
  assign misalignM = misalC & ~rst;
  assign buserrM   = buserrC & ~rst;

  always_comb begin
    if (state == IDLE) begin
      dmem_we    = MemWriteM;
      dmem_addr  = combAddr;
      dmem_wmask = combMask;
      dmem_wdata = combWdata;
    end else begin
      dmem_we    = reqWe;
      dmem_addr  = reqAddr;
      dmem_wmask = reqMask;
      dmem_wdata = reqWdata;
    end
  end

  // ---------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUoutW   <= '0;
      ReadDataW <= '0;
      rdW       <= '0;
      MemtoRegW <= 1'b0;
      RegWriteW <= 1'b0;
    end else if (!stall) begin
      ALUoutW   <= ALUoutM;
      ReadDataW <= (done && MemReadM) ? loadData : '0;
      rdW       <= rdM;
      MemtoRegW <= MemtoRegM;
      RegWriteW <= validM & RegWriteM & ~fail;
    end else begin
      // Held entry must not be written back again on every stalled cycle
      RegWriteW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_bus.sv
module tb_mem_stage_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic        validM;
  logic [2:0]  strCtrlM;
  logic        RegWriteM, MemWriteM, MemReadM, MemtoRegM;
  logic [31:0] ALUoutM, r2M;
  logic [4:0]  rdM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stallM, misalignM, buserrM;
  logic [31:0] ALUoutW, ReadDataW;
  logic [4:0]  rdW;
  logic        MemtoRegW, RegWriteW;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  mem_stage_bus #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .validM(validM), .strCtrlM(strCtrlM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .MemtoRegM(MemtoRegM), .ALUoutM(ALUoutM), .r2M(r2M), .rdM(rdM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stallM(stallM),
    .misalignM(misalignM), .buserrM(buserrM), .ALUoutW(ALUoutW),
    .ReadDataW(ReadDataW), .rdW(rdW), .MemtoRegW(MemtoRegW),
    .RegWriteW(RegWriteW)
  );

  task automatic setIdle();
    validM = 0; strCtrlM = 0; RegWriteM = 0; MemWriteM = 0; MemReadM = 0;
    MemtoRegM = 0; ALUoutM = 0; r2M = 0; rdM = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic nopCycle();
    @(negedge clk);
    setIdle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setIdle();
    @(negedge clk); #1;
    nChecks++; if (stallM !== 1'b0) begin nFail++; $display("FAIL reset_stall: got %0b want 0", stallM); end
    nChecks++; if (dmem_req !== 1'b0) begin nFail++; $display("FAIL reset_req: got %0b want 0", dmem_req); end
    nChecks++; if ({misalignM, buserrM} !== 2'b00) begin nFail++; $display("FAIL reset_pulses: got %b want 00", {misalignM, buserrM}); end
    nChecks++; if ({ALUoutW, ReadDataW, rdW, MemtoRegW, RegWriteW} !== 71'd0) begin nFail++; $display("FAIL reset_wreg: got %h/%h/%h/%b/%b want all 0", ALUoutW, ReadDataW, rdW, MemtoRegW, RegWriteW); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    @(negedge clk);
    setIdle();
    validM = 1; RegWriteM = 1; ALUoutM = 32'h1234; rdM = 5;
    #1;
    nChecks++; if (stallM !== 1'b0) begin nFail++; $display("FAIL add_stall: got %0b want 0", stallM); end
    nChecks++; if (dmem_req !== 1'b0) begin nFail++; $display("FAIL add_req: got %0b want 0", dmem_req); end
    @(posedge clk); #1;
    nChecks++; if (ALUoutW !== 32'h1234) begin nFail++; $display("FAIL add_aluoutW: got %h want 00001234", ALUoutW); end
    nChecks++; if (rdW !== 5'd5) begin nFail++; $display("FAIL add_rdW: got %0d want 5", rdW); end
    nChecks++; if (RegWriteW !== 1'b1) begin nFail++; $display("FAIL add_regwriteW: got %0b want 1", RegWriteW); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    setIdle();
    validM = 1; RegWriteM = 0; MemtoRegM = 1; ALUoutM = 32'hCAFE0000; rdM = 31;
    @(posedge clk); #1;
    nChecks++; if ({ALUoutW, rdW, MemtoRegW, RegWriteW} !== {32'hCAFE0000, 5'd31, 1'b1, 1'b0}) begin nFail++; $display("FAIL b2b_wreg: got %h/%0d/%b/%b want cafe0000/31/1/0", ALUoutW, rdW, MemtoRegW, RegWriteW); end
  endtask

  task automatic test_store();
    // SB to 0x103, zero-wait bus
    @(negedge clk);
    setIdle();
    validM = 1; MemWriteM = 1; strCtrlM = 3'b000; ALUoutM = 32'h103; r2M = 32'hAB;
    dmem_gnt = 1; dmem_rvalid = 1;
    #1;
    nChecks++; if ({dmem_req, dmem_we} !== 2'b11) begin nFail++; $display("FAIL sb_req_we: got %b want 11", {dmem_req, dmem_we}); end
    nChecks++; if (dmem_wmask !== 4'b1000) begin nFail++; $display("FAIL sb_wmask: got %b want 1000", dmem_wmask); end
    nChecks++; if (dmem_wdata !== 32'hABABABAB) begin nFail++; $display("FAIL sb_wdata: got %h want abababab", dmem_wdata); end
    nChecks++; if (dmem_addr !== 32'h100) begin nFail++; $display("FAIL sb_addr: got %h want 00000100", dmem_addr); end
    nChecks++; if (stallM !== 1'b0) begin nFail++; $display("FAIL sb_stall: got %0b want 0", stallM); end
    @(posedge clk); #1;
    nChecks++; if (RegWriteW !== 1'b0) begin nFail++; $display("FAIL sb_regwriteW: got %0b want 0", RegWriteW); end
    // SH to 0x002
    @(negedge clk);
    strCtrlM = 3'b001; ALUoutM = 32'h2; r2M = 32'h1234BEEF;
    #1;
    nChecks++; if ({dmem_wmask, dmem_wdata, dmem_addr} !== {4'b1100, 32'hBEEFBEEF, 32'h0}) begin nFail++; $display("FAIL sh_lanes: got %b/%h/%h want 1100/beefbeef/00000000", dmem_wmask, dmem_wdata, dmem_addr); end
    nChecks++; if (stallM !== 1'b0) begin nFail++; $display("FAIL sh_stall: got %0b want 0", stallM); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_half(input logic uns, input logic [31:0] want);
    int stallCnt = 0;
    @(negedge clk);
    setIdle();
    validM = 1; MemReadM = 1; RegWriteM = 1; MemtoRegM = 1;
    strCtrlM = {uns, 2'b01}; ALUoutM = 32'h202; rdM = 7; dmem_rdata = 32'h8001FFFF;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      dmem_gnt = (c == 2); dmem_rvalid = (c == 5);
      #1;
      if (stallM) stallCnt++;
      nChecks++; if (dmem_req !== (c <= 2)) begin nFail++; $display("FAIL lh_req_c%0d: got %0b want %0b", c, dmem_req, (c <= 2)); end
      if (c <= 2) begin
        nChecks++; if ({dmem_addr, dmem_we} !== {32'h200, 1'b0}) begin nFail++; $display("FAIL lh_addr_c%0d: got %h/%b want 00000200/0", c, dmem_addr, dmem_we); end
      end
      @(posedge clk); #1;
      if (c < 5) begin
        nChecks++; if (RegWriteW !== 1'b0) begin nFail++; $display("FAIL lh_held_regwrite_c%0d: got %0b want 0", c, RegWriteW); end
      end
    end
    nChecks++; if (stallCnt != 5) begin nFail++; $display("FAIL lh_stall_cycles: got %0d want 5", stallCnt); end
    nChecks++; if (ReadDataW !== want) begin nFail++; $display("FAIL lh_readdataW: got %h want %h", ReadDataW, want); end
    nChecks++; if ({RegWriteW, MemtoRegW, rdW} !== {1'b1, 1'b1, 5'd7}) begin nFail++; $display("FAIL lh_wctrl: got %b/%b/%0d want 1/1/7", RegWriteW, MemtoRegW, rdW); end
    nopCycle();
  endtask

  task automatic test_load_byte(input logic uns, input logic [31:0] want);
    @(negedge clk);
    setIdle();
    validM = 1; MemReadM = 1; RegWriteM = 1; MemtoRegM = 1;
    strCtrlM = {uns, 2'b00}; ALUoutM = 32'h1; rdM = 3;
    dmem_rdata = 32'h00008000; dmem_gnt = 1; dmem_rvalid = 1;
    #1;
    nChecks++; if (stallM !== 1'b0) begin nFail++; $display("FAIL lb_stall: got %0b want 0", stallM); end
    @(posedge clk); #1;
    nChecks++; if ({ReadDataW, RegWriteW} !== {want, 1'b1}) begin nFail++; $display("FAIL lb_result: got %h/%b want %h/1", ReadDataW, RegWriteW, want); end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    setIdle();
    validM = 1; MemReadM = 1; RegWriteM = 1; strCtrlM = 3'b010; ALUoutM = 32'h6; rdM = 9;
    dmem_gnt = 1; dmem_rvalid = 1;
    #1;
    nChecks++; if (misalignM !== 1'b1) begin nFail++; $display("FAIL lw_misalign: got %0b want 1", misalignM); end
    nChecks++; if ({dmem_req, stallM} !== 2'b00) begin nFail++; $display("FAIL lw_misalign_reqstall: got %b want 00", {dmem_req, stallM}); end
    @(posedge clk); #1;
    nChecks++; if (RegWriteW !== 1'b0) begin nFail++; $display("FAIL lw_misalign_regwriteW: got %0b want 0", RegWriteW); end
    // misaligned halfword store
    @(negedge clk);
    MemReadM = 0; MemWriteM = 1; RegWriteM = 0; strCtrlM = 3'b001; ALUoutM = 32'h1;
    #1;
    nChecks++; if ({misalignM, dmem_req} !== 2'b10) begin nFail++; $display("FAIL sh_misalign: got %b want 10", {misalignM, dmem_req}); end
    @(negedge clk);
    setIdle();
    #1;
    nChecks++; if (misalignM !== 1'b0) begin nFail++; $display("FAIL misalign_pulse_end: got %0b want 0", misalignM); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    setIdle();
    validM = 1; MemReadM = 1; RegWriteM = 1; strCtrlM = 3'b010; ALUoutM = 32'h40; rdM = 4;
    dmem_gnt = 1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c > 0) dmem_gnt = 0;
      #1;
      nChecks++; if (buserrM !== (c == 5)) begin nFail++; $display("FAIL to_buserr_c%0d: got %0b want %0b", c, buserrM, (c == 5)); end
      nChecks++; if (stallM !== (c != 5)) begin nFail++; $display("FAIL to_stall_c%0d: got %0b want %0b", c, stallM, (c != 5)); end
      @(posedge clk); #1;
    end
    nChecks++; if (RegWriteW !== 1'b0) begin nFail++; $display("FAIL to_regwriteW: got %0b want 0", RegWriteW); end
    @(negedge clk);
    setIdle();
    #1;
    nChecks++; if ({buserrM, stallM, dmem_req} !== 3'b000) begin nFail++; $display("FAIL to_idle: got %b want 000", {buserrM, stallM, dmem_req}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midtxn();
    @(negedge clk);
    setIdle();
    validM = 1; RegWriteM = 1; ALUoutM = 32'h1234; rdM = 5;
    @(posedge clk); #1;
    @(negedge clk);
    validM = 1; MemReadM = 1; MemtoRegM = 1; RegWriteM = 1; strCtrlM = 3'b010;
    ALUoutM = 32'h80; rdM = 6; dmem_gnt = 1;
    @(posedge clk); #1;
    @(negedge clk);
    dmem_gnt = 0;
    #1;
    nChecks++; if (stallM !== 1'b1) begin nFail++; $display("FAIL rstmid_prestall: got %0b want 1", stallM); end
    rst = 1'b1;
    #1;
    nChecks++; if ({stallM, dmem_req, buserrM, misalignM} !== 4'b0000) begin nFail++; $display("FAIL rstmid_outs: got %b want 0000", {stallM, dmem_req, buserrM, misalignM}); end
    nChecks++; if ({ALUoutW, rdW, RegWriteW} !== 38'd0) begin nFail++; $display("FAIL rstmid_wreg: got %h/%0d/%b want 0/0/0", ALUoutW, rdW, RegWriteW); end
    @(negedge clk);
    rst = 1'b0;
    setIdle();
    dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    nChecks++; if (stallM !== 1'b0) begin nFail++; $display("FAIL rstmid_late_stall: got %0b want 0", stallM); end
    @(posedge clk); #1;
    nChecks++; if ({RegWriteW, ReadDataW} !== 33'd0) begin nFail++; $display("FAIL rstmid_late_rvalid: got %b/%h want 0/0", RegWriteW, ReadDataW); end
    nopCycle();
  endtask

  initial begin
    setIdle();
    test_reset();
    test_add();
    test_back_to_back();
    test_store();
    test_load_half(1'b0, 32'hFFFF8001);
    test_load_half(1'b1, 32'h00008001);
    test_load_byte(1'b0, 32'hFFFFFF80);
    test_load_byte(1'b1, 32'h00000080);
    test_misalign();
    test_timeout();
    test_reset_midtxn();
    test_add();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/mem_stage_bus.md
Name: mem_stage_bus

Overview:
- Next-generation MEM pipeline stage for the 5-stage RV32 core.
- Data memory is reached over an external variable-latency req/gnt/rvalid bus instead of an internal single-cycle array.
- Generates byte/halfword/word write masks, aligns and sign-extends load data, and detects misaligned accesses.
- Stalls the pipeline while a bus transaction is outstanding and enforces a response timeout. Registers results into the MEM/WB pipeline register.

Parameters:
- ADDR_W, 32, width of dmem_addr; low ADDR_W bits of ALUoutM are driven.
- TIMEOUT, 255, max cycles from grant to rvalid before bus error; must be >=1, counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- validM  in  1  instruction in MEM is valid (not a bubble)
- strCtrlM  in  3  funct3: [1:0] 00=byte 01=half 10=word; [2]=1 unsigned load
- RegWriteM, MemWriteM, MemReadM, MemtoRegM  in  1 each  control from EX/MEM
- ALUoutM  in  32  effective address / ALU result
- r2M  in  32  store data (unshifted)
- rdM  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  1=store
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0)
- dmem_wmask  out  4  byte enables
- dmem_wdata  out  32  store data replicated into lanes
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  response valid (loads and stores both respond)
- dmem_rdata  in  32  load word
- stallM  out  1  freeze IF..MEM stages
- misalignM  out  1  pulse: misaligned access
- buserrM  out  1  pulse: response timeout
- ALUoutW, ReadDataW  out  32 each  MEM/WB register
- rdW  out  5  MEM/WB register
- MemtoRegW, RegWriteW  out  1 each  MEM/WB register

Behaviour:
- Access: acc = validM & (MemReadM|MemWriteM).
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned access: no bus request; misalignM=1 for one cycle; W register captures RegWriteW=0.
- Write mask:
  - byte: 0001<<addr[1:0]
  - half: 0011<<(addr[1]*2)
  - word: 1111
- Store data lanes:
  - byte: r2M[7:0] replicated x4
  - half: r2M[15:0] x2
  - word: r2M
- Load format:
  - half = addr[1] ? rdata[31:16] : rdata[15:0]
  - byte selected by addr[1:0]
  - sign-extend unless strCtrlM[2]=1
- FSM states IDLE, REQ, WAIT.
  - IDLE: aligned acc -> REQ (dmem_req=1 combinationally the same cycle, stallM=1); otherwise pass-through, no stall.
  - REQ: hold req/we/addr/wmask/wdata stable until dmem_gnt. gnt -> WAIT, timer cleared. gnt & rvalid in the same cycle -> treat as done.
  - WAIT: stallM=1, timer++. rvalid -> done. Timer reaches TIMEOUT -> buserrM pulse, W register gets RegWriteW=0, -> IDLE.
  - done: capture formatted ReadDataM into W register. stallM=0 in that cycle so the pipeline advances. -> IDLE.
  - Zero-wait bus (gnt & rvalid in the first cycle): the access completes with stallM=0 and 0 extra cycles.
- W register:
  - Updates only when stallM=0.
  - While stalled, holds its value but RegWriteW is forced 0, so a held writeback is never re-written twice.
  - Non-memory instructions pass through in one cycle (latency 1, identical to a plain pipeline register).
- Reset (any time, incl. mid-transaction):
  - state=IDLE; timer=0; dmem_req=0.
  - stallM=0, misalignM=0, buserrM=0.
  - All W outputs 0.
  - A late rvalid after reset is ignored.
- rvalid while IDLE/REQ without prior gnt: ignored.

Test Plan:
- SB to addr 0x103, r2M=0x000000AB, zero-wait bus -> dmem_wmask=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, stallM never 1.
- LH at 0x202, rdata=0x8001FFFF, gnt after 2 cycles, rvalid 3 cycles later -> stallM high 5 cycles; then ReadDataW=0xFFFF8001, RegWriteW=1. Repeat with LHU -> 0x00008001.
- LW at 0x006 -> misalignM pulse, dmem_req never asserted, RegWriteW=0, no stall.
- LW granted, no rvalid for TIMEOUT=4 -> buserrM pulses after 4 WAIT cycles, FSM returns to IDLE, RegWriteW=0.
- Assert rst during WAIT -> all outputs 0 immediately (async); a later rvalid produces no writeback.
- ADD (no mem access), ALUoutM=0x1234, rdM=5 -> next cycle ALUoutW=0x1234, rdW=5, RegWriteW=1, no stall.
